// File: rtl/bus_port_pkg.sv
// Shared types and helpers for the bus port adapter: packet layout, ID extraction
// and saturating status-counter arithmetic.
package bus_port_pkg;

  localparam int ID_W      = 8;
  localparam int CNT_W     = 16;
  localparam int PAY_W     = 8;
  localparam int PKT_MAX_W = 64;

  // Layout of the default 16-bit packet; wider packets keep the ID in the top byte.
  typedef struct packed {
    logic [ID_W-1:0]  dest;
    logic [PAY_W-1:0] payload;
  } packet_t;

  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                               input int pckg_sz);
    return ID_W'(pkt >> (pckg_sz - ID_W));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers. A write into a
// full FIFO succeeds when a read happens in the same cycle; an empty FIFO is never bypassed.
module fifo_sync_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign wr_ptr_d = do_wr ? wr_ptr_q + PTR_INC : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + PTR_INC : rd_ptr_q;

  // Outputs are masked to zero while empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers define validity, and a resettable array costs flops.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/bus_port_adapter.sv
// Terminal-side adapter for one arbiter port: TX buffering towards the arbiter,
// destination filtering of deliveries into an RX buffer, and saturating status.
module bus_port_adapter
  import bus_port_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter logic [ID_W-1:0] my_id     = 8'd0,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [pckg_sz-1:0] rx_data,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   misroute_cnt,
  output logic               err_underflow
);

  logic            tx_full, tx_empty;
  logic            rx_full, rx_empty;
  logic [ID_W-1:0] rx_dest;
  logic            dest_ok;
  logic            rx_drop;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] misroute_cnt_q, misroute_cnt_d;
  logic             err_underflow_q, err_underflow_d;

  // The TX FIFO accepts tx_valid while full if the arbiter pops the head in the same cycle.
  fifo_sync_fwft #(
    .WIDTH (pckg_sz),
    .DEPTH (depth)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign rx_dest = dest_of(PKT_MAX_W'(D_push), pckg_sz);
  assign dest_ok = (rx_dest == my_id) || (rx_dest == broadcast);
  assign rx_drop = push && dest_ok && rx_full && !rx_ready;

  fifo_sync_fwft #(
    .WIDTH (pckg_sz),
    .DEPTH (depth)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push && dest_ok),
    .wr_data (D_push),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign tx_ready = !tx_full;
  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    drop_cnt_d      = drop_cnt_q;
    misroute_cnt_d  = misroute_cnt_q;
    err_underflow_d = err_underflow_q;
    if (push && !dest_ok) begin
      misroute_cnt_d = sat_inc(misroute_cnt_q);
    end
    if (rx_drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    if (pop && tx_empty) begin
      err_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q      <= '0;
      misroute_cnt_q  <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      drop_cnt_q      <= drop_cnt_d;
      misroute_cnt_q  <= misroute_cnt_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign drop_cnt      = drop_cnt_q;
  assign misroute_cnt  = misroute_cnt_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_bus_port_adapter.sv
// Scoreboard bench for bus_port_adapter: a queue-based reference model fills the
// expected queues, a negedge monitor checks every transfer and the status outputs.
module tb_bus_port_adapter;
  import bus_port_pkg::*;

  localparam int        W  = 16;
  localparam int        D  = 4;
  localparam logic [7:0] ID = 8'd3;
  localparam logic [7:0] BC = 8'hFF;

  logic         clk = 1'b0;
  logic         reset, tx_valid, pop, push, rx_ready;
  logic [W-1:0] tx_data, D_push;
  logic         tx_ready, pndng, rx_valid, err_underflow;
  logic [W-1:0] D_pop, rx_data;
  logic [15:0]  drop_cnt, misroute_cnt;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] tx_exp[$];
  logic [W-1:0] rx_exp[$];
  int m_tx_cnt = 0, m_rx_cnt = 0, m_drop = 0, m_mis = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  bus_port_adapter #(
    .pckg_sz   (W),
    .depth     (D),
    .my_id     (ID),
    .broadcast (BC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .pndng         (pndng),
    .pop           (pop),
    .D_pop         (D_pop),
    .push          (push),
    .D_push        (D_push),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .drop_cnt      (drop_cnt),
    .misroute_cnt  (misroute_cnt),
    .err_underflow (err_underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: FIFO occupancies as plain counts, contents as queues.
  always @(posedge clk) begin : model
    bit pop_ok, wr_ok, rd_ok, wr_rx;
    logic [7:0] dest;
    if (reset) begin
      m_tx_cnt = 0; m_rx_cnt = 0; m_drop = 0; m_mis = 0; m_err = 1'b0;
      tx_exp.delete();
      rx_exp.delete();
    end else begin
      pop_ok = pop && (m_tx_cnt > 0);
      if (pop && m_tx_cnt == 0) m_err = 1'b1;
      wr_ok = tx_valid && ((m_tx_cnt < D) || pop_ok);
      if (wr_ok) tx_exp.push_back(tx_data);
      m_tx_cnt = m_tx_cnt + int'(wr_ok) - int'(pop_ok);

      rd_ok = rx_ready && (m_rx_cnt > 0);
      wr_rx = 1'b0;
      if (push) begin
        dest = D_push[W-1 -: 8];
        if (dest != ID && dest != BC) begin
          if (m_mis < 65535) m_mis++;
        end else if (m_rx_cnt == D && !rx_ready) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          wr_rx = 1'b1;
          rx_exp.push_back(D_push);
        end
      end
      m_rx_cnt = m_rx_cnt + int'(wr_rx) - int'(rd_ok);
    end
  end

  always @(negedge clk) begin : monitor
    logic [W-1:0] exp;
    if (mon_en) begin
      check("pndng", 32'(pndng), 32'(m_tx_cnt > 0));
      check("tx_ready", 32'(tx_ready), 32'(m_tx_cnt < D));
      check("rx_valid", 32'(rx_valid), 32'(m_rx_cnt > 0));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
      check("err_underflow", 32'(err_underflow), 32'(m_err));
      if (m_tx_cnt == 0) check("D_pop_masked", 32'(D_pop), 32'd0);
      if (m_rx_cnt == 0) check("rx_data_masked", 32'(rx_data), 32'd0);
      if (pndng && pop) begin
        if (tx_exp.size() == 0) check("tx_pop_unexpected", 32'(pndng), 32'd0);
        else begin
          exp = tx_exp.pop_front();
          check("tx_head", 32'(D_pop), 32'(exp));
        end
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) check("rx_read_unexpected", 32'(rx_valid), 32'd0);
        else begin
          exp = rx_exp.pop_front();
          check("rx_head", 32'(rx_data), 32'(exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_valid = 1'b0; pop = 1'b0; push = 1'b0; rx_ready = 1'b0;
  endtask

  initial begin
    packet_t pkt;
    int ph;
    reset = 1'b1; tx_data = '0; D_push = '0;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_pndng", 32'(pndng), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_D_pop", 32'(D_pop), 32'd0);

    // Basic TX path.
    tx_valid = 1'b1; tx_data = 16'h0501; tick();
    tx_data = 16'h0702; tick();
    tx_valid = 1'b0;
    check("tx1_pndng", 32'(pndng), 32'd1);
    check("tx1_head0", 32'(D_pop), 32'h0501);
    pop = 1'b1; tick();
    check("tx1_head1", 32'(D_pop), 32'h0702);
    tick();
    pop = 1'b0;
    check("tx1_empty", 32'(pndng), 32'd0);

    // TX full, then simultaneous pop and write while full.
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 16'h0310 + 16'(i); tick();
    end
    tx_data = 16'h0909; tick(); tick();
    check("tx2_full_ready", 32'(tx_ready), 32'd0);
    check("tx2_head", 32'(D_pop), 32'h0310);
    pop = 1'b1; tick();
    pop = 1'b0; tx_valid = 1'b0;
    check("tx2_still_full", 32'(tx_ready), 32'd0);
    check("tx2_head_after", 32'(D_pop), 32'h0311);
    pop = 1'b1; repeat (4) tick();
    pop = 1'b0;
    check("tx2_drained", 32'(pndng), 32'd0);

    // RX filtering.
    push = 1'b1;
    D_push = 16'h03AA; tick();
    D_push = 16'hFFBB; tick();
    D_push = 16'h04CC; tick();
    push = 1'b0;
    check("rx3_misroute", 32'(misroute_cnt), 32'd1);
    check("rx3_head", 32'(rx_data), 32'h03AA);
    rx_ready = 1'b1; repeat (2) tick();
    rx_ready = 1'b0;
    check("rx3_empty", 32'(rx_valid), 32'd0);

    // RX overflow, then a push while full with rx_ready high.
    push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      D_push = 16'h0310 + 16'(i); tick();
    end
    push = 1'b0;
    check("rx4_drop", 32'(drop_cnt), 32'd2);
    push = 1'b1; D_push = 16'h0377; rx_ready = 1'b1; tick();
    push = 1'b0; rx_ready = 1'b0;
    check("rx4_drop_hold", 32'(drop_cnt), 32'd2);
    check("rx4_head", 32'(rx_data), 32'h0311);
    rx_ready = 1'b1; repeat (4) tick();
    rx_ready = 1'b0;
    check("rx4_empty", 32'(rx_valid), 32'd0);

    // Underflow is sticky and leaves the FIFO usable.
    pop = 1'b1; tick();
    pop = 1'b0;
    check("uf_flag", 32'(err_underflow), 32'd1);
    check("uf_pndng", 32'(pndng), 32'd0);
    tx_valid = 1'b1; tx_data = 16'h0ABC; tick();
    tx_valid = 1'b0;
    check("uf_head", 32'(D_pop), 32'h0ABC);
    pop = 1'b1; tick();
    pop = 1'b0;
    check("uf_sticky", 32'(err_underflow), 32'd1);

    // Reset mid-operation, with traffic in the reset cycle itself.
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 16'h0600 + 16'(i);
      push = (i < 2); D_push = 16'h0360 + 16'(i);
      tick();
    end
    idle();
    check("rs_pndng_pre", 32'(pndng), 32'd1);
    check("rs_rx_pre", 32'(rx_valid), 32'd1);
    reset = 1'b1; tx_valid = 1'b1; push = 1'b1; tick();
    reset = 1'b0; idle();
    check("rs_pndng", 32'(pndng), 32'd0);
    check("rs_rx_valid", 32'(rx_valid), 32'd0);
    check("rs_tx_ready", 32'(tx_ready), 32'd1);
    check("rs_drop", 32'(drop_cnt), 32'd0);
    check("rs_misroute", 32'(misroute_cnt), 32'd0);
    check("rs_err", 32'(err_underflow), 32'd0);

    // Randomised traffic, alternating bias so both FIFOs hit full and empty.
    for (int c = 0; c < 3000; c++) begin
      ph = (c / 250) % 2;
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 16'($urandom);
      pop      = ($urandom % 4) < (ph != 0 ? 3 : 1);
      case ($urandom % 4)
        0:       pkt.dest = ID;
        1:       pkt.dest = BC;
        2:       pkt.dest = 8'($urandom);
        default: pkt.dest = ID;
      endcase
      pkt.payload = 8'($urandom);
      D_push   = pkt;
      push     = 1'($urandom_range(0, 1));
      rx_ready = ($urandom % 4) < (ph != 0 ? 1 : 3);
      reset    = ($urandom % 600) == 0;
      tick();
    end
    reset = 1'b0; idle();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
